// File: rtl/dma_to_finn_adapter.sv
// Serialises DMA MM2S words into model-width samples for the FINN input stream,
// tracking frame length against DMA TLAST and flagging mismatches.
module dma_to_finn_adapter #(
    parameter int unsigned IN_DATA_WIDTH  = 32,
    parameter int unsigned OUT_DATA_WIDTH = 8,
    parameter bit          PACKED         = 1'b0,
    parameter int unsigned FRAME_LEN      = 784
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_axis_tvalid,
    input  logic [IN_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic                      m_axis_tvalid,
    output logic [OUT_DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                      m_axis_tready,
    output logic                      frame_done,
    output logic                      err_tlast_early,
    output logic                      err_tlast_missing,
    input  logic                      err_clr
);

    localparam int unsigned LANES  = IN_DATA_WIDTH / OUT_DATA_WIDTH;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    // In unpacked mode every beat is the last lane, so lane_idx never leaves 0.
    localparam logic [LANE_W-1:0] LAST_LANE = PACKED ? LANE_W'(LANES - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN - 1);

    if (IN_DATA_WIDTH % OUT_DATA_WIDTH != 0) begin : g_chk_width
        $error("IN_DATA_WIDTH must be a multiple of OUT_DATA_WIDTH");
    end
    if (PACKED && (FRAME_LEN % LANES != 0)) begin : g_chk_frame
        $error("FRAME_LEN must be a multiple of LANES in packed mode");
    end

    logic [IN_DATA_WIDTH-1:0] r_word;
    logic                     r_last;
    logic                     r_valid;
    logic [LANE_W-1:0]        r_lane;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_frame_done;
    logic                     r_err_early;
    logic                     r_err_missing;

    logic              w_lane_last;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_last_beat;
    logic [LANE_W-1:0] w_lane_d;
    logic [CNT_W-1:0]  w_cnt_d;
    logic              w_done_d;
    logic              w_set_early;
    logic              w_set_missing;

    assign w_lane_last   = (r_lane == LAST_LANE);
    assign s_axis_tready = !r_valid || (m_axis_tready && w_lane_last);
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_out_hs      = r_valid && m_axis_tready;
    assign w_last_beat   = w_out_hs && w_lane_last;

    assign m_axis_tvalid     = r_valid;
    assign frame_done        = r_frame_done;
    assign err_tlast_early   = r_err_early;
    assign err_tlast_missing = r_err_missing;

    always_comb begin
        m_axis_tdata = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_lane == LANE_W'(l)) begin
                m_axis_tdata = r_word[l*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_lane_d      = r_lane;
        w_cnt_d       = r_cnt;
        w_done_d      = 1'b0;
        w_set_early   = 1'b0;
        w_set_missing = 1'b0;
        if (w_out_hs) begin
            w_lane_d = w_lane_last ? '0 : r_lane + LANE_W'(1);
            if (w_lane_last && r_last) begin
                w_cnt_d     = '0;
                w_done_d    = 1'b1;
                w_set_early = (r_cnt != CNT_LAST);
            end else if (r_cnt == CNT_LAST) begin
                w_cnt_d       = '0;
                w_done_d      = 1'b1;
                w_set_missing = 1'b1;
            end else begin
                w_cnt_d = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word        <= '0;
            r_last        <= 1'b0;
            r_valid       <= 1'b0;
            r_lane        <= '0;
            r_cnt         <= '0;
            r_frame_done  <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            if (w_in_hs) begin
                r_word <= s_axis_tdata;
                r_last <= s_axis_tlast;
            end
            if (w_in_hs) begin
                r_valid <= 1'b1;
            end else if (w_last_beat) begin
                r_valid <= 1'b0;
            end
            r_lane       <= w_lane_d;
            r_cnt        <= w_cnt_d;
            r_frame_done <= w_done_d;
            // A set in the same cycle as err_clr takes priority.
            if (w_set_early) begin
                r_err_early <= 1'b1;
            end else if (err_clr) begin
                r_err_early <= 1'b0;
            end
            if (w_set_missing) begin
                r_err_missing <= 1'b1;
            end else if (err_clr) begin
                r_err_missing <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_to_finn_adapter.sv
// Scoreboard bench: instance "a" is unpacked with FRAME_LEN=4, instance "b" is packed
// (4 lanes) with FRAME_LEN=8.
module tb_dma_to_finn_adapter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_s_tvalid, a_s_tlast, a_s_tready, a_m_tvalid, a_m_tready;
    logic [31:0] a_s_tdata;
    logic [7:0]  a_m_tdata;
    logic        a_frame_done, a_err_early, a_err_missing, a_err_clr;
    logic        b_s_tvalid, b_s_tlast, b_s_tready, b_m_tvalid, b_m_tready;
    logic [31:0] b_s_tdata;
    logic [7:0]  b_m_tdata;
    logic        b_frame_done, b_err_early, b_err_missing, b_err_clr;

    dma_to_finn_adapter #(
        .IN_DATA_WIDTH (32),
        .OUT_DATA_WIDTH(8),
        .PACKED        (1'b0),
        .FRAME_LEN     (4)
    ) u_dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tvalid    (a_s_tvalid),
        .s_axis_tdata     (a_s_tdata),
        .s_axis_tlast     (a_s_tlast),
        .s_axis_tready    (a_s_tready),
        .m_axis_tvalid    (a_m_tvalid),
        .m_axis_tdata     (a_m_tdata),
        .m_axis_tready    (a_m_tready),
        .frame_done       (a_frame_done),
        .err_tlast_early  (a_err_early),
        .err_tlast_missing(a_err_missing),
        .err_clr          (a_err_clr)
    );

    dma_to_finn_adapter #(
        .IN_DATA_WIDTH (32),
        .OUT_DATA_WIDTH(8),
        .PACKED        (1'b1),
        .FRAME_LEN     (8)
    ) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tvalid    (b_s_tvalid),
        .s_axis_tdata     (b_s_tdata),
        .s_axis_tlast     (b_s_tlast),
        .s_axis_tready    (b_s_tready),
        .m_axis_tvalid    (b_m_tvalid),
        .m_axis_tdata     (b_m_tdata),
        .m_axis_tready    (b_m_tready),
        .frame_done       (b_frame_done),
        .err_tlast_early  (b_err_early),
        .err_tlast_missing(b_err_missing),
        .err_clr          (b_err_clr)
    );

    logic [7:0] a_exp_q[$];
    logic [7:0] b_exp_q[$];
    int         a_pop_cyc[$];
    int         b_pop_cyc[$];
    int         a_done_cnt = 0, b_done_cnt = 0, a_done_cyc = 0;
    int         b_rdy_low = 0, b_rdy_hi = 0;
    logic [7:0] a_exp_v, b_exp_v, b_stall_d;
    logic       b_stall = 1'b0;

    // Monitors sample mid-cycle; a valid&&ready here is the handshake at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_m_tvalid && a_m_tready) begin
                n_tests++;
                if (a_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_sample: got %h, required no sample", a_m_tdata);
                end else begin
                    a_exp_v = a_exp_q.pop_front();
                    if (a_m_tdata !== a_exp_v) begin
                        n_fail++;
                        $display("FAIL a_sample: got %h, required %h", a_m_tdata, a_exp_v);
                    end
                end
                a_pop_cyc.push_back(cyc);
            end
            if (a_frame_done) begin
                a_done_cnt++;
                a_done_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_stall = 1'b0;
        end else begin
            if (b_stall) begin
                n_tests++;
                if (!(b_m_tvalid === 1'b1 && b_m_tdata === b_stall_d)) begin
                    n_fail++;
                    $display("FAIL b_stall_stable: got v=%b d=%h, required v=1 d=%h",
                             b_m_tvalid, b_m_tdata, b_stall_d);
                end
            end
            b_stall   = b_m_tvalid && !b_m_tready;
            b_stall_d = b_m_tdata;
            if (b_m_tvalid && b_m_tready) begin
                n_tests++;
                if (b_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_sample: got %h, required no sample", b_m_tdata);
                end else begin
                    b_exp_v = b_exp_q.pop_front();
                    if (b_m_tdata !== b_exp_v) begin
                        n_fail++;
                        $display("FAIL b_sample: got %h, required %h", b_m_tdata, b_exp_v);
                    end
                end
                b_pop_cyc.push_back(cyc);
            end
            if (b_m_tvalid && !b_s_tready) b_rdy_low++;
            if (b_m_tvalid && b_s_tready) b_rdy_hi++;
            if (b_frame_done) b_done_cnt++;
        end
    end

    task automatic send_a(input logic [31:0] d, input logic l);
        bit ok = 1'b0;
        a_s_tvalid = 1'b1;
        a_s_tdata  = d;
        a_s_tlast  = l;
        a_exp_q.push_back(d[7:0]);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = a_s_tready;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_send_timeout: got tready=0, required 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        a_s_tvalid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic l);
        bit ok = 1'b0;
        b_s_tvalid = 1'b1;
        b_s_tdata  = d;
        b_s_tlast  = l;
        for (int k = 0; k < 4; k++) b_exp_q.push_back(d[k*8 +: 8]);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = b_s_tready;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_send_timeout: got tready=0, required 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        b_s_tvalid = 1'b0;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 200 && a_exp_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (a_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL a_drain: got %0d pending, required 0", a_exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain_b();
        for (int i = 0; i < 200 && b_exp_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (b_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b_drain: got %0d pending, required 0", b_exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_errs();
        a_err_clr = 1'b1;
        b_err_clr = 1'b1;
        @(posedge clk);
        #1;
        a_err_clr = 1'b0;
        b_err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {a_s_tvalid, a_s_tlast, a_err_clr, b_s_tvalid, b_s_tlast, b_err_clr} = '0;
        a_s_tdata  = '0;
        b_s_tdata  = '0;
        a_m_tready = 1'b1;
        b_m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({a_m_tvalid, a_s_tready, a_m_tdata, a_frame_done, a_err_early, a_err_missing}
            !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL a_reset: got v=%b rdy=%b d=%h fd=%b ee=%b em=%b, required 0 1 00 0 0 0",
                     a_m_tvalid, a_s_tready, a_m_tdata, a_frame_done, a_err_early,
                     a_err_missing);
        end
        n_tests++;
        if ({b_m_tvalid, b_s_tready, b_m_tdata, b_frame_done, b_err_early, b_err_missing}
            !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b_reset: got v=%b rdy=%b d=%h fd=%b ee=%b em=%b, required 0 1 00 0 0 0",
                     b_m_tvalid, b_s_tready, b_m_tdata, b_frame_done, b_err_early,
                     b_err_missing);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unpacked();
        int d0 = a_done_cnt;
        int gaps = 0;
        a_pop_cyc.delete();
        send_a(32'hAABBCC01, 1'b0);
        send_a(32'h00000002, 1'b0);
        send_a(32'h00000003, 1'b0);
        send_a(32'h00000004, 1'b1);
        drain_a();
        for (int i = 1; i < a_pop_cyc.size(); i++) begin
            if (a_pop_cyc[i] != a_pop_cyc[i-1] + 1) gaps++;
        end
        n_tests++;
        if (a_pop_cyc.size() != 4 || gaps != 0) begin
            n_fail++;
            $display("FAIL unp_consecutive: got %0d samples %0d gaps, required 4 samples 0 gaps",
                     a_pop_cyc.size(), gaps);
        end
        n_tests++;
        if (a_done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL unp_frame_done: got %0d pulses, required 1", a_done_cnt - d0);
        end
        n_tests++;
        if (a_pop_cyc.size() == 4 && a_done_cyc != a_pop_cyc[3] + 1) begin
            n_fail++;
            $display("FAIL unp_done_timing: got cycle %0d, required %0d",
                     a_done_cyc, a_pop_cyc[3] + 1);
        end
        n_tests++;
        if ({a_err_early, a_err_missing} !== 2'b00) begin
            n_fail++;
            $display("FAIL unp_errs: got %b%b, required 00", a_err_early, a_err_missing);
        end
    endtask

    task automatic test_packed();
        int d0 = b_done_cnt;
        int gaps = 0;
        b_pop_cyc.delete();
        b_rdy_low = 0;
        b_rdy_hi  = 0;
        send_b(32'h44332211, 1'b0);
        send_b(32'h88776655, 1'b1);
        drain_b();
        for (int i = 1; i < b_pop_cyc.size(); i++) begin
            if (b_pop_cyc[i] != b_pop_cyc[i-1] + 1) gaps++;
        end
        n_tests++;
        if (b_pop_cyc.size() != 8 || gaps != 0) begin
            n_fail++;
            $display("FAIL pk_consecutive: got %0d samples %0d gaps, required 8 samples 0 gaps",
                     b_pop_cyc.size(), gaps);
        end
        n_tests++;
        if (b_rdy_low != 6 || b_rdy_hi != 2) begin
            n_fail++;
            $display("FAIL pk_tready_duty: got low=%0d high=%0d, required low=6 high=2",
                     b_rdy_low, b_rdy_hi);
        end
        n_tests++;
        if (b_done_cnt - d0 != 1 || {b_err_early, b_err_missing} !== 2'b00) begin
            n_fail++;
            $display("FAIL pk_frame: got done=%0d errs=%b%b, required done=1 errs=00",
                     b_done_cnt - d0, b_err_early, b_err_missing);
        end
    endtask

    task automatic test_backpressure();
        int d0 = b_done_cnt;
        fork
            begin
                send_b(32'hDDCCBBAA, 1'b0);
                send_b(32'h5A4B3C2D, 1'b1);
            end
            begin
                for (int i = 0; i < 100 && (i < 2 || b_exp_q.size() != 0); i++) begin
                    b_m_tready = (i % 3 == 0);
                    @(posedge clk);
                    #1;
                end
                b_m_tready = 1'b1;
            end
        join
        drain_b();
        n_tests++;
        if (b_done_cnt - d0 != 1 || {b_err_early, b_err_missing} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_frame: got done=%0d errs=%b%b, required done=1 errs=00",
                     b_done_cnt - d0, b_err_early, b_err_missing);
        end
    endtask

    task automatic test_early_tlast();
        int d0;
        clear_errs();
        d0 = a_done_cnt;
        send_a(32'h11, 1'b0);
        send_a(32'h12, 1'b1);
        drain_a();
        n_tests++;
        if ({a_err_early, a_err_missing} !== 2'b10 || a_done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL early_set: got errs=%b%b done=%0d, required errs=10 done=1",
                     a_err_early, a_err_missing, a_done_cnt - d0);
        end
        for (int i = 0; i < 4; i++) send_a(32'h20 + i, (i == 3));
        drain_a();
        n_tests++;
        if ({a_err_early, a_err_missing} !== 2'b10 || a_done_cnt - d0 != 2) begin
            n_fail++;
            $display("FAIL early_next_frame: got errs=%b%b done=%0d, required errs=10 done=2",
                     a_err_early, a_err_missing, a_done_cnt - d0);
        end
        clear_errs();
        n_tests++;
        if ({a_err_early, a_err_missing} !== 2'b00) begin
            n_fail++;
            $display("FAIL early_clr: got %b%b, required 00", a_err_early, a_err_missing);
        end
    endtask

    task automatic test_missing_tlast();
        int d0;
        clear_errs();
        d0 = a_done_cnt;
        for (int i = 0; i < 3; i++) send_a(32'h30 + i, 1'b0);
        drain_a();
        n_tests++;
        if (a_err_missing !== 1'b0 || a_done_cnt - d0 != 0) begin
            n_fail++;
            $display("FAIL miss_early: got em=%b done=%0d, required em=0 done=0",
                     a_err_missing, a_done_cnt - d0);
        end
        send_a(32'h33, 1'b0);
        drain_a();
        n_tests++;
        if (a_err_missing !== 1'b1 || a_done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL miss_set: got em=%b done=%0d, required em=1 done=1",
                     a_err_missing, a_done_cnt - d0);
        end
        send_a(32'h34, 1'b0);
        send_a(32'h35, 1'b0);
        send_a(32'h36, 1'b0);
        send_a(32'h37, 1'b1);
        drain_a();
        n_tests++;
        if (a_err_early !== 1'b0 || a_done_cnt - d0 != 2) begin
            n_fail++;
            $display("FAIL miss_new_frame: got ee=%b done=%0d, required ee=0 done=2",
                     a_err_early, a_done_cnt - d0);
        end
    endtask

    task automatic test_midframe_reset();
        int d0;
        clear_errs();
        b_m_tready = 1'b1;
        send_b(32'h04030201, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        b_exp_q.delete();
        #1;
        n_tests++;
        if ({b_m_tvalid, b_s_tready, b_m_tdata} !== {1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b rdy=%b d=%h, required v=0 rdy=1 d=00",
                     b_m_tvalid, b_s_tready, b_m_tdata);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        d0 = b_done_cnt;
        send_b(32'h0C0B0A09, 1'b0);
        send_b(32'h100F0E0D, 1'b1);
        drain_b();
        n_tests++;
        if (b_done_cnt - d0 != 1 || {b_err_early, b_err_missing} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_restart: got done=%0d errs=%b%b, required done=1 errs=00",
                     b_done_cnt - d0, b_err_early, b_err_missing);
        end
    endtask

    initial begin
        test_reset();
        test_unpacked();
        test_packed();
        test_backpressure();
        test_early_tlast();
        test_missing_tlast();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_to_finn_adapter.md
# dma_to_finn_adapter

AXI-Stream adapter between the DMA MM2S channel (32-bit words with TLAST) and the 8-bit input stream of the FINN stitched IP. It buffers one DMA word and serialises it into model-width samples, either one sample per word (low bits) or several packed samples per word. It also tracks frame boundaries against a fixed frame length and raises sticky errors when DMA TLAST and the expected frame length disagree. It is the input-side counterpart of the output FIFO feeding the DMA S2MM channel.

## Interface

- IN_DATA_WIDTH, 32, DMA word width (TDATA width on the slave side).
- OUT_DATA_WIDTH, 8, model input sample width. IN_DATA_WIDTH must be an integer multiple of OUT_DATA_WIDTH (elaboration error otherwise).
- PACKED, 0: 0 = one sample per word, taken from the low OUT_DATA_WIDTH bits, upper bits ignored; 1 = LANES = IN_DATA_WIDTH/OUT_DATA_WIDTH samples per word, lane 0 in the LSBs.
- FRAME_LEN, 784, samples per model input frame. In packed mode it must be a multiple of LANES (elaboration error otherwise).
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  DMA word valid.
- s_axis_tdata  in  IN_DATA_WIDTH  DMA word.
- s_axis_tlast  in  1  DMA end of transfer.
- s_axis_tready  out  1  adapter can accept a word.
- m_axis_tvalid  out  1  sample valid to the model.
- m_axis_tdata  out  OUT_DATA_WIDTH  sample.
- m_axis_tready  in  1  model accepts the sample.
- frame_done  out  1  one-cycle pulse on the transfer of the last sample of a frame.
- err_tlast_early  out  1  sticky flag: TLAST arrived before FRAME_LEN samples.
- err_tlast_missing  out  1  sticky flag: FRAME_LEN samples were sent without TLAST.
- err_clr  in  1  synchronous clear of both error flags.

## Operation

- State:
  - word register plus stored tlast bit;
  - word_valid;
  - lane_idx, width clog2(LANES), fixed at 0 when PACKED=0;
  - sample_cnt, width clog2(FRAME_LEN);
  - the error flags.
- Outputs:
  - m_axis_tvalid = word_valid.
  - m_axis_tdata = word[lane_idx*OUT_DATA_WIDTH +: OUT_DATA_WIDTH].
- Last-lane beat: an output handshake with lane_idx == LANES-1.
- s_axis_tready = !word_valid || (m_axis_tready && lane_idx == LANES-1). This is combinational and allows back-to-back words with no bubble.
- Slave handshake: loads the word and its tlast, and sets word_valid.
- Output handshake that is not a last-lane beat: lane_idx increments.
- Output handshake that is a last-lane beat: lane_idx returns to 0. word_valid clears unless a new word is loaded in the same cycle, in which case it stays 1.
- Frame tracking on each output handshake:
  - Last-lane beat with stored tlast = 1:
    - sample_cnt returns to 0 and frame_done pulses.
    - If sample_cnt != FRAME_LEN-1, set err_tlast_early.
  - Otherwise, if sample_cnt == FRAME_LEN-1:
    - sample_cnt returns to 0 and frame_done pulses.
    - Set err_tlast_missing.
  - Otherwise sample_cnt increments.
- err_clr: clears both flags. If a set condition occurs in the same cycle, set wins.
- No data is ever dropped or reordered. Errors are reported only; they do not stall the stream.

## Timing

- Reset values (asynchronous on rst_n low, held until release):
  - word_valid = 0, m_axis_tvalid = 0, s_axis_tready = 1.
  - lane_idx = 0, sample_cnt = 0.
  - frame_done = 0, both error flags = 0.
  - m_axis_tdata = 0 (word register cleared).
- Latency: a word accepted at edge N presents lane 0 on m_axis_tdata with m_axis_tvalid = 1 after edge N, i.e. in the following cycle.
- Throughput: one sample per cycle with the model always ready. The slave side sustains one word every LANES cycles.
- Stability: m_axis_tdata and m_axis_tvalid stay stable while m_axis_tvalid = 1 and m_axis_tready = 0. m_axis_tvalid never depends combinationally on m_axis_tready.
- frame_done and the error flags are registered: they are asserted in the cycle after the triggering handshake edge.
- Reset asserted mid-word or mid-frame discards the held word and the partial frame count. After release the next DMA word starts a new frame at lane 0.

## Test plan

- Unpacked (PACKED=0, FRAME_LEN=4): words 0xAABBCC01, 0x02, 0x03, 0x04, with tlast on the 4th, model always ready -> samples 01,02,03,04 on consecutive cycles; frame_done pulses once after the 04 transfer; no errors.
- Packed (PACKED=1, LANES=4, FRAME_LEN=8): words 0x44332211 then 0x88776655 (tlast), DMA valid continuously -> samples 11..88 on 8 consecutive cycles; s_axis_tready low for 3 of every 4 cycles; no bubble between 44 and 55.
- Backpressure: packed, m_axis_tready toggled 1,0,0,1,... -> every sample transferred exactly once, in order; tdata stable while stalled.
- Early TLAST: FRAME_LEN=4, tlast on the 2nd word -> err_tlast_early set, frame_done pulses, sample_cnt returns to 0; the next frame of 4 with correct tlast raises no new error; pulsing err_clr clears the flag.
- Missing TLAST: FRAME_LEN=4, 5 words with tlast on none -> err_tlast_missing set after the 4th transfer, frame_done pulses, and the 5th sample starts a new frame at count 0.
- Mid-frame reset: packed, assert rst_n low after 2 lanes of a word -> m_axis_tvalid = 0 and s_axis_tready = 1 immediately; after release the next word yields lane 0 first and the frame count restarts.
